// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM with parametrised memory wait states.
// Optional feature: define BRANCH_EXT_EN to add bne/blt/bge to the branch decode.
module multicycle_control_unit #(
    parameter int MEM_WAIT = 0,
    parameter int WAIT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    input  logic       Lt,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic       Illegal,
    output logic [3:0] State
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    logic [3:0]        r_state;
    logic [3:0]        w_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              w_last;
    logic              w_mem_state;
    logic              w_alu_ok;
    logic [2:0]        w_func;
    logic              w_br_ok;
    logic              w_taken;
    logic              w_unused;

    assign w_unused    = &{1'b0, Lt, funct7[6], funct7[4:0]};
    assign w_last      = (r_wait_cnt == WAIT_W'(MEM_WAIT));
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
    assign State       = r_state;

    // ALU function for EXECR/EXECI; op[5] separates R-type (sub allowed) from I-type.
    always_comb begin
        w_alu_ok = 1'b1;
        w_func   = 3'b000;
        case (funct3)
            3'b000:  w_func = (op[5] && funct7[5]) ? 3'b001 : 3'b000;
            3'b010:  w_func = 3'b101;
            3'b110:  w_func = 3'b011;
            3'b111:  w_func = 3'b010;
            default: w_alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_br_ok = 1'b1;
        w_taken = 1'b0;
        case (funct3)
            3'b000:  w_taken = Zero;
`ifdef BRANCH_EXT_EN
            3'b001:  w_taken = ~Zero;
            3'b100:  w_taken = Lt;
            3'b101:  w_taken = ~Lt;
`endif
            default: w_br_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (w_last) w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BR:        w_next = S_BRANCH;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (w_last) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (w_last) w_next = S_FETCH;
            S_EXECR,
            S_EXECI:    w_next = w_alu_ok ? S_ALUWB : S_TRAP;
            S_ALUWB:    w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_BRANCH:   w_next = w_br_ok ? S_FETCH : S_TRAP;
            default:    w_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (w_mem_state)
                r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Mux selects follow the state; strobes in memory states fire only on the final wait cycle.
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        RegWrite   = 1'b0;
        Illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = w_last;
                PCWrite   = w_last;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = w_last;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = w_func;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = w_func;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = 3'b001;
                PCWrite    = w_br_ok && w_taken;
            end
            S_TRAP:     Illegal = 1'b1;
            default:    Illegal = 1'b1;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            Illegal  = 1'b0;
        end
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 3'b001;
            OP_BR:   ImmSrc = 3'b010;
            OP_JAL:  ImmSrc = 3'b011;
            default: ImmSrc = 3'b000;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: two instances (MEM_WAIT 0 and 2) checked
// cycle by cycle against a per-instruction expected state/output sequence.
module tb_multicycle_control_unit;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BR = 7'b1100011;
    localparam logic [18:0] ALL     = 19'h7FFFF;
    localparam logic [18:0] NOALU   = 19'h7FFE3;
    localparam logic [18:0] STROBES = 19'h05803;

    logic       clk = 1'b0;
    logic       tb_rst = 1'b1;
    int         sel = 0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       Zero = 1'b0;
    logic       Lt = 1'b0;

    logic       rst [2];
    logic       pcw [2], adr [2], memw [2], irw [2], rw [2], ill [2];
    logic [1:0] rs [2], sa [2], sb [2];
    logic [2:0] alu [2], imm [2];
    logic [3:0] st [2];
    logic [18:0] obs_v [2];

    int n_checks = 0;
    int n_fail   = 0;
    logic [18:0] exp_q[$];
    logic [18:0] msk_q[$];
    bit trapped;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        assign rst[gi]   = tb_rst || (sel != gi);
        assign obs_v[gi] = {st[gi], pcw[gi], adr[gi], memw[gi], irw[gi], rs[gi], sa[gi], sb[gi],
                            alu[gi], rw[gi], ill[gi]};
        multicycle_control_unit #(.MEM_WAIT(gi * 2), .WAIT_W(4)) dut (
            .clk(clk), .reset(rst[gi]), .op(op), .funct3(funct3), .funct7(funct7),
            .Zero(Zero), .Lt(Lt), .PCWrite(pcw[gi]), .AdrSrc(adr[gi]), .MemWrite(memw[gi]),
            .IRWrite(irw[gi]), .ResultSrc(rs[gi]), .ALUSrcA(sa[gi]), .ALUSrcB(sb[gi]),
            .ALUControl(alu[gi]), .ImmSrc(imm[gi]), .RegWrite(rw[gi]), .Illegal(ill[gi]),
            .State(st[gi])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [18:0] pk(input int s, input bit pc, a, mw, ir,
                                       input int r, ya, yb, al, input bit w, il);
        return {4'(s), pc, a, mw, ir, 2'(r), 2'(ya), 2'(yb), 3'(al), w, il};
    endfunction

    function automatic int exp_imm(input logic [6:0] o);
        case (o)
            LW, IT:  return 0;
            SW:      return 1;
            BR:      return 2;
            JL:      return 3;
            default: return -1;
        endcase
    endfunction

    task automatic push(input logic [18:0] v, input logic [18:0] m);
        exp_q.push_back(v);
        msk_q.push_back(m);
    endtask

    // Expected per-cycle outputs for one instruction, derived from the instruction class.
    task automatic build(input int w, input logic [6:0] o, input logic [2:0] f3,
                         input logic [6:0] f7, input bit z, input bit l);
        int  fn;
        bit  ok, tk;
        exp_q.delete();
        msk_q.delete();
        trapped = 0;
        for (int k = 0; k <= w; k++) push(pk(0, k == w, 0, 0, k == w, 2, 0, 2, 0, 0, 0), ALL);
        push(pk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), ALL);
        if (o == LW || o == SW) begin
            push(pk(2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0), ALL);
            if (o == LW) begin
                for (int k = 0; k <= w; k++) push(pk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), ALL);
                push(pk(4, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0), ALL);
            end else begin
                for (int k = 0; k <= w; k++) push(pk(5, 0, 1, k == w, 0, 0, 0, 0, 0, 0, 0), ALL);
            end
        end else if (o == RT || o == IT) begin
            ok = 1;
            fn = 0;
            case (f3)
                3'b000:  fn = (o[5] && f7[5]) ? 1 : 0;
                3'b010:  fn = 5;
                3'b110:  fn = 3;
                3'b111:  fn = 2;
                default: ok = 0;
            endcase
            push(pk(o == RT ? 6 : 7, 0, 0, 0, 0, 0, 2, o == RT ? 0 : 1, fn, 0, 0), ok ? ALL : NOALU);
            if (ok) push(pk(8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), ALL);
            else trapped = 1;
        end else if (o == JL) begin
            push(pk(10, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0), ALL);
            push(pk(8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), ALL);
        end else if (o == BR) begin
            ok = (f3 == 3'b000);
            tk = z;
`ifdef BRANCH_EXT_EN
            ok = ok || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101;
            if (f3 == 3'b001) tk = !z;
            if (f3 == 3'b100) tk = l;
            if (f3 == 3'b101) tk = !l;
`else
            tk = tk || (l && 1'b0);
`endif
            push(pk(9, ok && tk, 0, 0, 0, 0, 2, 0, 1, 0, 0), ALL);
            if (!ok) trapped = 1;
        end else begin
            trapped = 1;
        end
        if (trapped)
            for (int k = 0; k < 10; k++) push(pk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ALL);
    endtask

    // Leaves reset asserted; the next run() releases it on its first cycle.
    task automatic do_reset();
        @(negedge clk);
        tb_rst = 1'b1;
        #1 check_eq("rst_strobes", 32'(obs_v[sel] & STROBES), 32'd0);
        @(negedge clk);
        #1 check_eq("rst_state", 32'(st[sel]), 32'd0);
        check_eq("rst_strobes2", 32'(obs_v[sel] & STROBES), 32'd0);
    endtask

    task automatic run(input int s, input logic [6:0] o, input logic [2:0] f3,
                       input logic [6:0] f7, input bit z, input bit l, input int abort_at);
        int ei;
        build(s * 2, o, f3, f7, z, l);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                sel = s; op = o; funct3 = f3; funct7 = f7; Zero = z; Lt = l;
                tb_rst = 1'b0;
            end
            if (i == abort_at) begin
                tb_rst = 1'b1;
                #1 check_eq("abort_gated", 32'(obs_v[sel] & msk_q[i]), 32'(exp_q[i] & ~STROBES));
                return;
            end
            #1 check_eq($sformatf("op%07b f3%0d c%0d", o, f3, i), 32'(obs_v[sel] & msk_q[i]),
                        32'(exp_q[i] & msk_q[i]));
            if (i == 0) begin
                ei = exp_imm(o);
                if (ei >= 0) check_eq("immsrc", 32'(imm[sel]), 32'(ei));
            end
        end
        $display("instr dut_wait=%0d op=%07b f3=%03b f7b5=%0b Z=%0b Lt=%0b cycles=%0d trap=%0b",
                 s * 2, o, f3, f7[5], z, l, exp_q.size(), trapped);
        if (trapped) do_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ro;
        logic [2:0] rf;
        int         r;
        do_reset();
        run(0, LW, 3'b010, 7'd0, 0, 0, -1);
        run(0, RT, 3'b000, 7'b0100000, 0, 0, -1);
        run(0, BR, 3'b000, 7'd0, 1, 0, -1);
        run(0, BR, 3'b000, 7'd0, 0, 0, -1);
        run(0, IT, 3'b010, 7'b0100000, 0, 0, -1);
        run(0, JL, 3'b000, 7'd0, 0, 0, -1);
        run(0, 7'b1110011, 3'b000, 7'd0, 0, 0, -1);
        run(0, BR, 3'b001, 7'd0, 0, 1, -1);
        run(1, SW, 3'b010, 7'd0, 0, 0, -1);
        run(1, LW, 3'b010, 7'd0, 0, 0, -1);
        run(1, SW, 3'b010, 7'd0, 0, 0, 6);
        run(1, SW, 3'b010, 7'd0, 0, 0, -1);
        run(1, BR, 3'b100, 7'd0, 1, 1, -1);
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       ro = LW;
                1:       ro = SW;
                2, 3:    ro = RT;
                4:       ro = IT;
                5:       ro = JL;
                6, 7:    ro = BR;
                default: begin
                    case ($urandom_range(0, 2))
                        0:       ro = 7'b1110011;
                        1:       ro = 7'b0110111;
                        default: ro = 7'b0000000;
                    endcase
                end
            endcase
            if ((ro == RT || ro == IT) && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 3))
                    0:       rf = 3'b000;
                    1:       rf = 3'b010;
                    2:       rf = 3'b110;
                    default: rf = 3'b111;
                endcase
            end else if (ro == BR && $urandom_range(0, 1) == 0) begin
                rf = 3'b000;
            end else begin
                rf = 3'($urandom_range(0, 7));
            end
            run((n / 15) % 2, ro, rf, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
